mem_req_mux: RTL and testbench

MEM_REQ_MUX -- requirements
Module: mem_req_mux

---
 rtl/mem_req_mux_if.sv | 22 ++
 rtl/mem_req_mux.sv | 105 ++++++++++
 tb/tb_mem_req_mux.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/mem_req_mux_if.sv
// Memory request mux bus bundle: two dual-rail sources, one dual-rail sink and the 4-phase acks.
// The master modport is the side that drives the requests; the slave modport is the mux itself.
interface mem_req_mux_if;
    logic [15:0] instr_data;
    logic [15:0] cache_data;
    logic        ack_out_instr;
    logic        ack_out_cache;
    logic [15:0] mem_data;
    logic [1:0]  PH0;
    logic        ack_in;
    logic        err;

    modport master (
        output instr_data, cache_data, ack_in,
        input  ack_out_instr, ack_out_cache, mem_data, PH0, err
    );

    modport slave (
        input  instr_data, cache_data, ack_in,
        output ack_out_instr, ack_out_cache, mem_data, PH0, err
    );
endinterface

// File: rtl/mem_req_mux.sv
// Two-source dual-rail request mux with alternating-priority arbitration and a 4-phase
// handshake on both sides (IDLE -> DRIVE -> RELEASE); all outputs come straight from registers.
module mem_req_mux (
    input  logic          clk,
    input  logic          rst_n,
    mem_req_mux_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, DRIVE, RELEASE} state_t;

    state_t      state_reg;
    logic [15:0] mem_data_reg;
    logic [1:0]  ph0_reg;
    logic        ack_instr_reg;
    logic        ack_cache_reg;
    logic        err_reg;
    logic        grant_cache_reg;
    logic        last_cache_reg;

    logic [7:0]  instr_pair_ok;
    logic [7:0]  instr_pair_bad;
    logic [7:0]  cache_pair_ok;
    logic [7:0]  cache_pair_bad;
    logic        instr_complete;
    logic        cache_complete;
    logic        instr_illegal;
    logic        cache_illegal;
    logic        instr_null;
    logic        cache_null;
    logic        pick_cache;

    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_pair
            assign instr_pair_ok[gi]  = bus.instr_data[2*gi+1] ^ bus.instr_data[2*gi];
            assign instr_pair_bad[gi] = bus.instr_data[2*gi+1] & bus.instr_data[2*gi];
            assign cache_pair_ok[gi]  = bus.cache_data[2*gi+1] ^ bus.cache_data[2*gi];
            assign cache_pair_bad[gi] = bus.cache_data[2*gi+1] & bus.cache_data[2*gi];
        end
    endgenerate

    assign instr_complete = &instr_pair_ok;
    assign cache_complete = &cache_pair_ok;
    assign instr_illegal  = |instr_pair_bad;
    assign cache_illegal  = |cache_pair_bad;
    assign instr_null     = (bus.instr_data == 16'h0000);
    assign cache_null     = (bus.cache_data == 16'h0000);

    // On a tie the source that did not win last time takes the grant.
    assign pick_cache = cache_complete && (!instr_complete || !last_cache_reg);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg       <= IDLE;
            mem_data_reg    <= 16'h0000;
            ph0_reg         <= 2'b00;
            ack_instr_reg   <= 1'b0;
            ack_cache_reg   <= 1'b0;
            err_reg         <= 1'b0;
            grant_cache_reg <= 1'b0;
            last_cache_reg  <= 1'b1;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (instr_illegal || cache_illegal) begin
                        err_reg <= 1'b1;
                    end
                    if (instr_complete || cache_complete) begin
                        grant_cache_reg <= pick_cache;
                        last_cache_reg  <= pick_cache;
                        mem_data_reg    <= pick_cache ? bus.cache_data : bus.instr_data;
                        ph0_reg         <= pick_cache ? 2'b01 : 2'b10;
                        state_reg       <= DRIVE;
                    end
                end
                DRIVE: begin
                    if (bus.ack_in) begin
                        mem_data_reg <= 16'h0000;
                        ph0_reg      <= 2'b00;
                        if (grant_cache_reg) begin
                            ack_cache_reg <= 1'b1;
                        end else begin
                            ack_instr_reg <= 1'b1;
                        end
                        state_reg <= RELEASE;
                    end
                end
                RELEASE: begin
                    // Return to IDLE only once memory and the granted source have both gone NULL.
                    if (!bus.ack_in && (grant_cache_reg ? cache_null : instr_null)) begin
                        ack_instr_reg <= 1'b0;
                        ack_cache_reg <= 1'b0;
                        state_reg     <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign bus.mem_data      = mem_data_reg;
    assign bus.PH0           = ph0_reg;
    assign bus.ack_out_instr = ack_instr_reg;
    assign bus.ack_out_cache = ack_cache_reg;
    assign bus.err           = err_reg;
endmodule

// File: tb/tb_mem_req_mux.sv
// Directed bench for mem_req_mux: expected grants are queued when requests are driven and
// popped when the mux presents a word on PH0/mem_data.
module tb_mem_req_mux;
    logic clk;
    logic rst_n;
    int   errors;
    int   checks;

    typedef struct {
        logic [1:0]  tag;
        logic [15:0] word;
    } exp_t;

    exp_t sb[$];

    localparam logic [1:0]  TAG_I  = 2'b10;
    localparam logic [1:0]  TAG_C  = 2'b01;
    localparam logic [15:0] W_A5   = 16'h9966;
    localparam logic [15:0] W_3C   = 16'h5AA5;
    localparam logic [15:0] W_BAD  = 16'h5AA7;

    mem_req_mux_if bus ();

    mem_req_mux dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_mem"}, {16'h0, bus.mem_data}, 32'h0);
        check({tag, "_ph0"}, {30'h0, bus.PH0}, 32'h0);
        check({tag, "_acki"}, {31'h0, bus.ack_out_instr}, 32'h0);
        check({tag, "_ackc"}, {31'h0, bus.ack_out_cache}, 32'h0);
    endtask

    task automatic wait_grant(input string tag, output exp_t e);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (bus.PH0 == 2'b00 && n < 20);
        checks++;
        assert (bus.PH0 !== 2'b00) else begin
            errors++;
            $error("FAIL %s_timeout: PH0=%b expected nonzero after %0d cycles", tag, bus.PH0, n);
        end
        checks++;
        assert (sb.size() != 0) else begin
            errors++;
            $error("FAIL %s_sb: observed grant with empty scoreboard, expected none", tag);
        end
        if (sb.size() != 0) e = sb.pop_front();
        else e = '{2'b00, 16'h0000};
        check({tag, "_ph0"}, {30'h0, bus.PH0}, {30'h0, e.tag});
        check({tag, "_mem"}, {16'h0, bus.mem_data}, {16'h0, e.word});
        check({tag, "_acki_lo"}, {31'h0, bus.ack_out_instr}, 32'h0);
        check({tag, "_ackc_lo"}, {31'h0, bus.ack_out_cache}, 32'h0);
    endtask

    task automatic finish_txn(input string tag, input exp_t e, input logic redrive);
        bus.ack_in = 1'b1;
        @(negedge clk);
        check({tag, "_rel_mem"}, {16'h0, bus.mem_data}, 32'h0);
        check({tag, "_rel_ph0"}, {30'h0, bus.PH0}, 32'h0);
        check({tag, "_rel_acki"}, {31'h0, bus.ack_out_instr}, {31'h0, (e.tag == TAG_I)});
        check({tag, "_rel_ackc"}, {31'h0, bus.ack_out_cache}, {31'h0, (e.tag == TAG_C)});
        bus.ack_in = 1'b0;
        if (e.tag == TAG_I) bus.instr_data = 16'h0000;
        else bus.cache_data = 16'h0000;
        @(negedge clk);
        check({tag, "_done_acki"}, {31'h0, bus.ack_out_instr}, 32'h0);
        check({tag, "_done_ackc"}, {31'h0, bus.ack_out_cache}, 32'h0);
        $display("txn %s tag=%b word=%h", tag, e.tag, e.word);
        if (redrive) begin
            if (e.tag == TAG_I) bus.instr_data = e.word;
            else bus.cache_data = e.word;
            sb.push_back(e);
        end
    endtask

    initial begin
        exp_t e;
        errors = 0;
        checks = 0;
        bus.instr_data = 16'h0000;
        bus.cache_data = 16'h0000;
        bus.ack_in     = 1'b0;

        // Reset state
        @(negedge clk);
        do_reset();
        check_idle_outputs("reset");
        check("reset_err", {31'h0, bus.err}, 32'h0);

        // Single instruction transaction
        bus.instr_data = W_A5;
        sb.push_back('{TAG_I, W_A5});
        wait_grant("single", e);
        finish_txn("single", e, 1'b0);

        // ack_in high while IDLE is ignored
        bus.ack_in = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check_idle_outputs("idle_ack");
        bus.ack_in = 1'b0;
        @(negedge clk);

        // Simultaneous after reset: instruction first, then cache
        do_reset();
        bus.instr_data = W_A5;
        bus.cache_data = W_3C;
        sb.push_back('{TAG_I, W_A5});
        sb.push_back('{TAG_C, W_3C});
        wait_grant("sim_i", e);
        finish_txn("sim_i", e, 1'b0);
        wait_grant("sim_c", e);
        finish_txn("sim_c", e, 1'b0);

        // Back-to-back simultaneous requests alternate
        do_reset();
        bus.instr_data = W_A5;
        bus.cache_data = W_3C;
        sb.push_back('{TAG_I, W_A5});
        sb.push_back('{TAG_C, W_3C});
        for (int k = 0; k < 4; k++) begin
            wait_grant($sformatf("alt%0d", k), e);
            check($sformatf("alt%0d_order", k), {30'h0, e.tag}, (k % 2 == 0) ? {30'h0, TAG_I} : {30'h0, TAG_C});
            finish_txn($sformatf("alt%0d", k), e, (k < 2));
        end

        // Illegal pair on cache sets sticky err and is never granted
        bus.cache_data = W_BAD;
        @(negedge clk);
        @(negedge clk);
        check("bad_err", {31'h0, bus.err}, 32'h1);
        check_idle_outputs("bad");
        bus.cache_data = 16'h0000;
        bus.instr_data = W_A5;
        sb.push_back('{TAG_I, W_A5});
        wait_grant("after_bad", e);
        check("bad_err_sticky", {31'h0, bus.err}, 32'h1);
        finish_txn("after_bad", e, 1'b0);

        // Reset while driving
        bus.instr_data = W_A5;
        sb.push_back('{TAG_I, W_A5});
        wait_grant("mid_rst", e);
        rst_n = 1'b0;
        @(negedge clk);
        check_idle_outputs("mid_rst");
        check("mid_rst_err", {31'h0, bus.err}, 32'h0);
        rst_n = 1'b1;
        sb.push_back('{TAG_I, W_A5});
        wait_grant("regrant", e);
        finish_txn("regrant", e, 1'b0);

        // Latched word holds while the source changes; ack_in=0 in DRIVE ignored
        bus.instr_data = W_A5;
        sb.push_back('{TAG_I, W_A5});
        wait_grant("hold", e);
        bus.instr_data = W_3C;
        @(negedge clk);
        @(negedge clk);
        check("hold_mem", {16'h0, bus.mem_data}, {16'h0, W_A5});
        check("hold_ph0", {30'h0, bus.PH0}, {30'h0, TAG_I});
        bus.ack_in = 1'b1;
        @(negedge clk);
        check("hold_rel_mem", {16'h0, bus.mem_data}, 32'h0);
        check("hold_rel_acki", {31'h0, bus.ack_out_instr}, 32'h1);
        // Source not yet NULL: stay in RELEASE
        bus.ack_in = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("hold_wait_acki", {31'h0, bus.ack_out_instr}, 32'h1);
        check("hold_wait_ph0", {30'h0, bus.PH0}, 32'h0);
        bus.instr_data = 16'h0000;
        @(negedge clk);
        check("hold_done_acki", {31'h0, bus.ack_out_instr}, 32'h0);
        $display("txn hold tag=%b word=%h", e.tag, e.word);

        check("sb_drained", sb.size(), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
